// File: rtl/buf_ex_stream_reader_if.sv
// buf_ex_stream_reader_if
//   Bundles the two data paths of the stream reader into one interface:
//   - the latency-1 buffer read port (buf_ex_addr out, buf_ex_data back)
//   - the output stream (m_valid/m_ready/m_data/m_last)
//   modport master : the reader side (drives address and stream beats)
//   modport slave  : the buffer + stream consumer side
interface buf_ex_stream_reader_if #(
  parameter int BUF_EX_ADDR_WIDTH = 8,
  parameter int BUF_EX_DATA_WIDTH = 256
);
  logic [BUF_EX_ADDR_WIDTH-1:0] buf_ex_addr;
  logic [BUF_EX_DATA_WIDTH-1:0] buf_ex_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [BUF_EX_DATA_WIDTH-1:0] m_data;
  logic                         m_last;

  modport master (
    output buf_ex_addr,
    input  buf_ex_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  buf_ex_addr,
    output buf_ex_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/buf_ex_stream_reader.sv
// buf_ex_stream_reader
//   Reads start_len consecutive words from a latency-1 buffer starting at
//   start_addr and emits them as a valid/ready stream, with m_last on the
//   final beat and a one-cycle done pulse after that beat is accepted.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     start, start_addr,
//     start_len          : transfer request (sampled in IDLE only)
//     abort              : synchronous cancel of a running transfer
//     busy, done         : status (busy in RUN/DRAIN, done pulse)
//     bus (master)       : buffer read port and output stream
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; zero-length start just pulses done
//   RUN   | issuing buffer reads, streaming words out of the FIFO
//   DRAIN | all reads issued, waiting for the m_last handshake
module buf_ex_stream_reader #(
  parameter int BUF_EX_ADDR_WIDTH = 8,
  parameter int BUF_EX_DATA_WIDTH = 256,
  parameter int LEN_WIDTH         = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [BUF_EX_ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]         start_len,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  buf_ex_stream_reader_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                       state_q;
  logic                         busy_q;
  logic                         done_q;
  logic [BUF_EX_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [LEN_WIDTH-1:0]         remaining_q;
  logic                         rd_pending_q;
  logic                         pend_last_q;

  // 2-entry output FIFO
  logic [BUF_EX_DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]                   fifo_last_q;
  logic                         wr_idx_q;
  logic                         rd_idx_q;
  logic [1:0]                   count_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic       head_last;
  logic       abort_act;
  logic [2:0] occ;

  assign pop       = (count_q != 2'd0) && bus.m_ready;
  assign push      = rd_pending_q;
  assign head_last = fifo_last_q[rd_idx_q];
  assign abort_act = abort && (state_q != IDLE);

  // Words already committed after this edge: buffered + in flight - leaving.
  // Keeping this below 2 guarantees the pushed read always finds a free slot.
  assign occ   = {1'b0, count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && !abort && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_ptr_q       <= '0;
      remaining_q    <= '0;
      rd_pending_q   <= 1'b0;
      pend_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_idx_q       <= 1'b0;
      rd_idx_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (abort_act) begin
        // Drop everything in flight; the read returning next cycle is ignored
        // because rd_pending is cleared here.
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        remaining_q  <= '0;
        rd_pending_q <= 1'b0;
        pend_last_q  <= 1'b0;
        wr_idx_q     <= 1'b0;
        rd_idx_q     <= 1'b0;
        count_q      <= 2'd0;
      end else begin
        rd_pending_q <= issue;
        if (issue) begin
          rd_ptr_q    <= rd_ptr_q + BUF_EX_ADDR_WIDTH'(1);
          remaining_q <= remaining_q - LEN_WIDTH'(1);
          pend_last_q <= (remaining_q == LEN_WIDTH'(1));
        end
        if (push) begin
          fifo_data_q[wr_idx_q] <= bus.buf_ex_data;
          fifo_last_q[wr_idx_q] <= pend_last_q;
          wr_idx_q              <= ~wr_idx_q;
        end
        if (pop) begin
          rd_idx_q <= ~rd_idx_q;
        end
        count_q <= count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
          IDLE: begin
            // abort wins over a coincident start
            if (start && !abort) begin
              if (start_len != '0) begin
                state_q     <= RUN;
                busy_q      <= 1'b1;
                rd_ptr_q    <= start_addr;
                remaining_q <= start_len;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (issue && (remaining_q == LEN_WIDTH'(1))) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && head_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.buf_ex_addr = rd_ptr_q;
  assign bus.m_valid     = (count_q != 2'd0);
  assign bus.m_data      = fifo_data_q[rd_idx_q];
  assign bus.m_last      = (count_q != 2'd0) && head_last;

endmodule

// File: tb/tb_buf_ex_stream_reader.sv
// tb_buf_ex_stream_reader
//   Scoreboard bench: stimulus pushes the expected beats of every transfer
//   into exp_q; a negedge monitor pops and compares on each handshake, and
//   also tracks done timing, stall stability and read occupancy.
module tb_buf_ex_stream_reader;
  localparam int AW = 8;
  localparam int DW = 256;
  localparam int LW = 9;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          abort;
  logic          busy;
  logic          done;

  buf_ex_stream_reader_if #(.BUF_EX_ADDR_WIDTH(AW), .BUF_EX_DATA_WIDTH(DW)) bus ();

  buf_ex_stream_reader #(
    .BUF_EX_ADDR_WIDTH(AW),
    .BUF_EX_DATA_WIDTH(DW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_addr(start_addr),
    .start_len(start_len),
    .abort(abort),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   pops = 0;
  logic done_chk_en = 1'b1;
  logic occ_en = 1'b0;
  logic [AW-1:0] occ_prev_addr;
  int   issued = 0;
  int   popped = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 8; i++) begin
      w[i*8 +: 8] = a ^ 8'(i * 37);
    end
    return w;
  endfunction

  // Latency-1 buffer model
  always @(posedge clk) bus.buf_ex_data <= word_of(bus.buf_ex_addr);

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d;
  logic          last_hs = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_v = 1'b0;
      last_hs = 1'b0;
    end else begin
      if (done_chk_en) check("done_timing", DW'(done), DW'(last_hs));
      last_hs = 1'b0;
      if (stall_v) check("stall_hold", {bus.m_valid, bus.m_data}, {1'b1, stall_d});
      if (occ_en) begin
        if (bus.buf_ex_addr != occ_prev_addr) begin
          issued++;
          occ_prev_addr = bus.buf_ex_addr;
        end
        n_checks++;
        if (issued - popped > 2) begin
          n_fail++;
          $display("FAIL occupancy: got %0d expected <=2", issued - popped);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h expected no beat", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.m_data, e.d);
          check("beat_last", DW'(bus.m_last), DW'(e.l));
          last_hs = e.l;
        end
        pops++;
        popped++;
      end
      stall_v = bus.m_valid && !bus.m_ready && !abort;
      stall_d = bus.m_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle and records the expected beats; returns at start edge + 1.
  task automatic start_xfer(logic [AW-1:0] a, logic [LW-1:0] len);
    exp_t e;
    start      = 1'b1;
    start_addr = a;
    start_len  = len;
    for (int i = 0; i < int'(len); i++) begin
      e.d = word_of(a + AW'(i));
      e.l = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(logic rand_ready);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !busy) break;
    end
    bus.m_ready = 1'b1;
    check("drain_empty", DW'(exp_q.size()), DW'(0));
    check("drain_busy", DW'(busy), DW'(0));
    tick();
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start_addr  = '0;
    start_len   = '0;
    abort       = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", DW'(bus.m_valid), DW'(0));
    check("rst_last", DW'(bus.m_last), DW'(0));
    check("rst_data", bus.m_data, '0);
    check("rst_addr", DW'(bus.buf_ex_addr), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    rst_n = 1'b1;
    tick();

    // Basic transfer: latency 2, four back-to-back beats, done after last
    start_xfer(8'h10, 9'd4);
    check("lat_t0_valid", DW'(bus.m_valid), DW'(0));
    check("lat_t0_busy", DW'(busy), DW'(1));
    tick();
    check("lat_t1_valid", DW'(bus.m_valid), DW'(0));
    tick();
    check("lat_t2_valid", DW'(bus.m_valid), DW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_valid", DW'(bus.m_valid), DW'(1));
    end
    tick();
    check("end_valid", DW'(bus.m_valid), DW'(0));
    check("end_busy", DW'(busy), DW'(0));
    check("end_done", DW'(done), DW'(1));
    tick();
    check("done_one_cycle", DW'(done), DW'(0));
    tick();

    // Address wrap
    start_xfer(8'hFE, 9'd4);
    check("wrap_addr0", DW'(bus.buf_ex_addr), DW'(8'hFE));
    tick();
    check("wrap_addr1", DW'(bus.buf_ex_addr), DW'(8'hFF));
    tick();
    check("wrap_addr2", DW'(bus.buf_ex_addr), DW'(8'h00));
    tick();
    check("wrap_addr3", DW'(bus.buf_ex_addr), DW'(8'h01));
    wait_idle(1'b0);

    // Zero length: done next cycle, nothing else
    done_chk_en = 1'b0;
    start_xfer(8'h33, 9'd0);
    check("zl_done", DW'(done), DW'(1));
    check("zl_busy", DW'(busy), DW'(0));
    check("zl_valid", DW'(bus.m_valid), DW'(0));
    tick();
    check("zl_done_low", DW'(done), DW'(0));
    check("zl_valid2", DW'(bus.m_valid), DW'(0));
    check("zl_busy2", DW'(busy), DW'(0));
    done_chk_en = 1'b1;
    tick();

    // Random backpressure, length 16, occupancy tracked
    start_xfer(8'h50, 9'd16);
    occ_prev_addr = 8'h50;
    issued        = 0;
    popped        = 0;
    occ_en        = 1'b1;
    wait_idle(1'b1);
    occ_en = 1'b0;
    check("occ_issued", DW'(issued), DW'(16));

    // Abort with FIFO full after two beats
    pops = 0;
    start_xfer(8'h60, 9'd8);
    for (int i = 0; i < 50; i++) begin
      if (pops >= 2) break;
      tick();
    end
    check("abort_pops", DW'(pops), DW'(2));
    bus.m_ready = 1'b0;
    repeat (4) tick();
    check("abort_pre_valid", DW'(bus.m_valid), DW'(1));
    check("abort_pre_busy", DW'(busy), DW'(1));
    abort = 1'b1;
    exp_q.delete();
    tick();
    abort = 1'b0;
    check("abort_valid", DW'(bus.m_valid), DW'(0));
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_done", DW'(done), DW'(0));
    bus.m_ready = 1'b1;
    repeat (5) tick();
    start_xfer(8'h40, 9'd3);
    wait_idle(1'b0);

    // Reset mid-transfer
    start_xfer(8'h80, 9'd8);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_valid", DW'(bus.m_valid), DW'(0));
    check("mrst_last", DW'(bus.m_last), DW'(0));
    check("mrst_data", bus.m_data, '0);
    check("mrst_addr", DW'(bus.buf_ex_addr), DW'(0));
    check("mrst_busy", DW'(busy), DW'(0));
    check("mrst_done", DW'(done), DW'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", DW'(bus.m_valid), DW'(0));
      check("post_rst_busy", DW'(busy), DW'(0));
    end
    start_xfer(8'h20, 9'd2);
    wait_idle(1'b0);

    check("final_queue", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buf_ex_stream_reader.md
BUF_EX_STREAM_READER -- requirements
Module: buf_ex_stream_reader

Interface
REQ-001 SHALL have parameter BUF_EX_ADDR_WIDTH, default 8: buffer read-address width.
REQ-002 SHALL have parameter BUF_EX_DATA_WIDTH, default 256: buffer read-data and stream width.
REQ-003 SHALL have parameter LEN_WIDTH, default 9: transfer-length width in words.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1: sole clock; all state on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: one-cycle request to begin a transfer; sampled only in IDLE.
REQ-008 Port start_addr, input, BUF_EX_ADDR_WIDTH: first buffer word; sampled with start.
REQ-009 Port start_len, input, LEN_WIDTH: word count; sampled with start.
REQ-010 Port abort, input, 1: synchronous cancel of the current transfer.
REQ-011 Port busy, output, 1: high in RUN and DRAIN.
REQ-012 Port done, output, 1: one-cycle pulse at completion.
REQ-013 Port buf_ex_addr, output, BUF_EX_ADDR_WIDTH: buffer read address, read latency 1, always enabled.
REQ-014 Port buf_ex_data, input, BUF_EX_DATA_WIDTH: buffer read data for the address presented one cycle earlier.
REQ-015 Port m_valid, output, 1: stream beat valid.
REQ-016 Port m_ready, input, 1: stream consumer ready.
REQ-017 Port m_data, output, BUF_EX_DATA_WIDTH: stream beat payload.
REQ-018 Port m_last, output, 1: marks the final beat of the transfer.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN.
REQ-020 IDLE: start=1 and start_len>0 -> RUN; rd_ptr<=start_addr, remaining<=start_len.
REQ-021 IDLE: start=1 and start_len=0 -> stay IDLE; done=1 the next cycle; no reads, no beats.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 buf_ex_addr SHALL equal rd_ptr at all times.
REQ-024 A read is issued in a RUN cycle when fifo_count + rd_pending - pop < 2, where pop = m_valid && m_ready.
REQ-025 On issue: rd_ptr increments modulo 2^BUF_EX_ADDR_WIDTH; remaining decrements; rd_pending<=1, else rd_pending<=0.
REQ-026 When rd_pending=1, buf_ex_data SHALL be pushed into a 2-entry output FIFO at that edge.
REQ-027 Each pushed word SHALL carry a last flag, set when it is the final word of the transfer.
REQ-028 m_valid/m_data/m_last SHALL be driven from the FIFO head; a beat transfers on m_valid && m_ready.
REQ-029 Once m_valid is high, m_data and m_last SHALL hold until handshake.
REQ-030 Simultaneous push and pop SHALL keep the count unchanged; the FIFO SHALL never overflow or lose data.
REQ-031 Issued reads outstanding plus buffered words SHALL never exceed 2.
REQ-032 RUN -> DRAIN when the last read issues; DRAIN -> IDLE on the m_last handshake.
REQ-033 done SHALL pulse exactly one cycle after the m_last handshake.
REQ-034 Latency: with m_ready=1, first m_valid 2 cycles after the start edge; then one beat per cycle.
REQ-035 abort in RUN/DRAIN SHALL take effect next edge: IDLE, FIFO emptied, rd_pending cleared, m_valid=0, no done.
REQ-036 abort in IDLE SHALL have no effect; abort has priority over start in the same cycle.

Reset
REQ-037 On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, buf_ex_addr=0, FIFO empty, rd_pending=0, remaining=0.
REQ-038 Reset mid-transfer SHALL discard all in-flight data; no beat or done SHALL appear after release without a new start.

Verification
REQ-039 start_addr=0x10, len=4, m_ready=1 -> m_valid 2 cycles after start, 4 back-to-back beats of words 0x10..0x13, m_last on beat 4, done 1 cycle later.
REQ-040 len=16, m_ready random 50% -> all 16 words in order, no duplicates, outstanding+buffered<=2, m_data stable while stalled.
REQ-041 start_addr=0xFE, len=4 -> buf_ex_addr sequence FE,FF,00,01; beats match those words.
REQ-042 start_len=0 -> done next cycle, m_valid stays 0, busy stays 0.
REQ-043 abort after beat 2 of len=8, m_ready=0 with FIFO full -> next cycle IDLE, m_valid=0, no done; new start works normally.
REQ-044 rst_n low mid-transfer -> all outputs at reset values immediately; after release no beats until a new start.
